// File: rtl/rf_write_arbiter_if.sv
// Handshake/bus bundle between WriteBack, the external result source and the
// register-file write port of rf_write_arbiter.
// slave  : the arbiter itself
// master : the surrounding pipeline / external unit / register file
interface rf_write_arbiter_if;
  logic        wb_write_enable;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_value;
  logic        wb_stall;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  ext_rd;
  logic [31:0] ext_value;
  logic [31:0] ext_pending_mask;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_value;

  modport slave (
    input  wb_write_enable, wb_write_reg, wb_write_value,
    input  ext_valid, ext_rd, ext_value,
    output wb_stall, ext_ready, ext_pending_mask,
    output rf_write_enable, rf_write_reg, rf_write_value
  );

  modport master (
    output wb_write_enable, wb_write_reg, wb_write_value,
    output ext_valid, ext_rd, ext_value,
    input  wb_stall, ext_ready, ext_pending_mask,
    input  rf_write_enable, rf_write_reg, rf_write_value
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: WriteBack has priority, external results
// are buffered in a small FIFO and drained on idle WriteBack cycles. A
// starvation counter forces a one-cycle WriteBack stall so the FIFO head
// always retires. A WriteBack write to R kills older queued entries for R;
// killed entries are dropped silently when they reach the head.
// Optional feature macro: RF_ARB_BYPASS_EN -- when the FIFO is empty and
// WriteBack does not write, an external result is written in the same cycle.
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                rst,
  rf_write_arbiter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   PTR_WRAP   = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    G_IDLE,
    G_WB,
    G_DRAIN,
    G_FORCE,
    G_BYPASS
  } grant_e;

  logic [4:0]       q_rd  [DEPTH];
  logic [31:0]      q_val [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      count;
  logic [SW-1:0]    starve_cnt;

  grant_e           grant;
  logic [AW-1:0]    head_idx;
  logic [AW-1:0]    tail_idx;
  logic             fifo_empty;
  logic             fifo_full;
  logic             head_live;
  logic             head_dead;
  logic             wb_req;
  logic             deq;
  logic             enq;
  logic             ext_ready_c;
  logic             rf_en_c;
  logic [4:0]       rf_reg_c;
  logic [31:0]      rf_val_c;
  logic [31:0]      pend_mask;

  assign head_idx = rd_ptr[AW-1:0];
  assign tail_idx = wr_ptr[AW-1:0];

  // Grant selection, dequeue/enqueue decisions and write-port mux.
  always_comb begin
    fifo_empty  = (count == '0);
    fifo_full   = ((wr_ptr ^ rd_ptr) == PTR_WRAP);
    head_live   = !fifo_empty && q_live[head_idx];
    head_dead   = !fifo_empty && !q_live[head_idx];
    wb_req      = bus.wb_write_enable && (bus.wb_write_reg != 5'd0);
    ext_ready_c = !rst && !fifo_full;

    grant = G_IDLE;
    if (rst)                                       grant = G_IDLE;
    else if (starve_cnt == STARVE_MAX && head_live) grant = G_FORCE;
    else if (wb_req)                                grant = G_WB;
    else if (head_live)                             grant = G_DRAIN;
`ifdef RF_ARB_BYPASS_EN
    else if (fifo_empty && bus.ext_valid && bus.ext_rd != 5'd0)
                                                    grant = G_BYPASS;
`endif

    deq = head_dead || (grant == G_FORCE) || (grant == G_DRAIN);
    enq = bus.ext_valid && ext_ready_c && (bus.ext_rd != 5'd0) && (grant != G_BYPASS);

    rf_en_c  = 1'b0;
    rf_reg_c = 5'd0;
    rf_val_c = 32'd0;
    case (grant)
      G_FORCE, G_DRAIN: begin
        rf_en_c  = 1'b1;
        rf_reg_c = q_rd[head_idx];
        rf_val_c = q_val[head_idx];
      end
      G_WB: begin
        rf_en_c  = 1'b1;
        rf_reg_c = bus.wb_write_reg;
        rf_val_c = bus.wb_write_value;
      end
      G_BYPASS: begin
        rf_en_c  = 1'b1;
        rf_reg_c = bus.ext_rd;
        rf_val_c = bus.ext_value;
      end
      default: ;
    endcase
  end

  // Pending-register mask over live (queued, not killed) entries.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) pend_mask[q_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign bus.wb_stall         = (grant == G_FORCE);
  assign bus.ext_ready        = ext_ready_c;
  assign bus.ext_pending_mask = pend_mask;
  assign bus.rf_write_enable  = rf_en_c;
  assign bus.rf_write_reg     = rf_reg_c;
  assign bus.rf_write_value   = rf_val_c;

  // FIFO control state: pointers, occupancy, live flags and starvation timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      q_live     <= '0;
    end else begin
      // Incoming entry is not yet queued, so a same-cycle WB write does not kill it.
      for (int i = 0; i < DEPTH; i++) begin
        if (grant == G_WB && q_live[i] && q_rd[i] == bus.wb_write_reg)
          q_live[i] <= 1'b0;
      end
      if (deq) begin
        q_live[head_idx] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (enq) begin
        q_live[tail_idx] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
      if (fifo_empty || deq)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // FIFO payload storage; contents are don't-care until marked live.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[tail_idx]  <= bus.ext_rd;
      q_val[tail_idx] <= bus.ext_value;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (DEPTH=4, STARVE_LIMIT=8).
// Directed scenarios plus a randomized run against a queue-based reference
// model. Honours RF_ARB_BYPASS_EN when defined.
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    bit          dead;
  } ent_t;

  typedef enum int {M_IDLE, M_WB, M_DRAIN, M_FORCE, M_BYP} mg_t;

  ent_t        mq[$];
  int          starve;
  mg_t         e_g;
  logic        e_en;
  logic [4:0]  e_reg;
  logic [31:0] e_val;
  logic        e_stall;
  logic        e_ready;
  logic [31:0] e_mask;

  function void model_expect();
    bit hl;
    hl      = (mq.size() > 0) && !mq[0].dead;
    e_g     = M_IDLE;
    e_en    = 1'b0;
    e_reg   = 5'd0;
    e_val   = 32'd0;
    e_stall = 1'b0;
    e_ready = 1'b0;
    e_mask  = 32'd0;
    if (rst) return;
    e_ready = (mq.size() < DEPTH);
    foreach (mq[i]) if (!mq[i].dead) e_mask = e_mask | (32'd1 << mq[i].rd);
    e_mask[0] = 1'b0;
    if (starve == LIMIT && hl) begin
      e_g = M_FORCE; e_en = 1'b1; e_reg = mq[0].rd; e_val = mq[0].val; e_stall = 1'b1;
    end else if (bus.wb_write_enable && bus.wb_write_reg != 5'd0) begin
      e_g = M_WB; e_en = 1'b1; e_reg = bus.wb_write_reg; e_val = bus.wb_write_value;
    end else if (hl) begin
      e_g = M_DRAIN; e_en = 1'b1; e_reg = mq[0].rd; e_val = mq[0].val;
    end else if (BYP && mq.size() == 0 && bus.ext_valid && bus.ext_rd != 5'd0) begin
      e_g = M_BYP; e_en = 1'b1; e_reg = bus.ext_rd; e_val = bus.ext_value;
    end
  endfunction

  function void model_advance();
    bit deq;
    if (rst) begin
      mq.delete();
      starve = 0;
      return;
    end
    model_expect();
    deq = (mq.size() > 0) && (mq[0].dead || e_g == M_FORCE || e_g == M_DRAIN);
    if (e_g == M_WB)
      foreach (mq[i]) if (mq[i].rd == bus.wb_write_reg) mq[i].dead = 1'b1;
    if (mq.size() == 0 || deq) starve = 0;
    else if (starve < LIMIT) starve++;
    if (deq) void'(mq.pop_front());
    if (bus.ext_valid && e_ready && bus.ext_rd != 5'd0 && e_g != M_BYP)
      mq.push_back('{rd: bus.ext_rd, val: bus.ext_value, dead: 1'b0});
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    bus.wb_write_enable = 1'b0;
    bus.wb_write_reg    = 5'd0;
    bus.wb_write_value  = 32'd0;
    bus.ext_valid       = 1'b0;
    bus.ext_rd          = 5'd0;
    bus.ext_value       = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    mq.delete();
    starve = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.wb_write_enable = 1'b1;
    bus.wb_write_reg    = 5'd5;
    bus.wb_write_value  = 32'h1234_5678;
    bus.ext_valid       = 1'b1;
    bus.ext_rd          = 5'd6;
    #2;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.wb_stall !== 1'b0 ||
        bus.ext_ready !== 1'b0 || bus.ext_pending_mask !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: en=%b stall=%b ready=%b mask=%h, required all 0",
               bus.rf_write_enable, bus.wb_stall, bus.ext_ready, bus.ext_pending_mask);
    end
    mq.delete();
    starve = 0;
    tick();
    tick();
    rst = 1'b0;
    drive_idle();
    #2;
    checks++;
    if (bus.ext_ready !== 1'b1 || bus.rf_write_enable !== 1'b0 || bus.ext_pending_mask !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b en=%b mask=%h, required ready=1 en=0 mask=0",
               bus.ext_ready, bus.rf_write_enable, bus.ext_pending_mask);
    end
    tick();
  endtask

  task automatic test_wb_only();
    do_reset();
    bus.wb_write_enable = 1'b1;
    bus.wb_write_reg    = 5'd5;
    bus.wb_write_value  = 32'hDEAD_BEEF;
    #2;
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd5 ||
        bus.rf_write_value !== 32'hDEAD_BEEF || bus.ext_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb_only: en=%b reg=%0d val=%h ready=%b, required 1/5/deadbeef/1",
               bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_value, bus.ext_ready);
    end
    tick();
    bus.wb_write_reg = 5'd0;
    #2;
    checks++;
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL wb_reg0: en=%b, required 0", bus.rf_write_enable);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_drain();
    do_reset();
    bus.ext_valid = 1'b1;
    bus.ext_rd    = 5'd7;
    bus.ext_value = 32'h11;
    #2;
    checks++;
    if (bus.rf_write_enable !== BYP) begin
      errors++;
      $display("FAIL drain_accept_cycle: en=%b, required %b", bus.rf_write_enable, BYP);
    end
    if (BYP) begin
      checks++;
      if (bus.rf_write_reg !== 5'd7 || bus.rf_write_value !== 32'h11) begin
        errors++;
        $display("FAIL drain_bypass: reg=%0d val=%h, required 7/11", bus.rf_write_reg, bus.rf_write_value);
      end
    end
    tick();
    bus.ext_valid = 1'b0;
    #2;
    if (!BYP) begin
      checks++;
      if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd7 ||
          bus.rf_write_value !== 32'h11 || bus.ext_pending_mask !== 32'h80) begin
        errors++;
        $display("FAIL drain_write: en=%b reg=%0d val=%h mask=%h, required 1/7/11/00000080",
                 bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_value, bus.ext_pending_mask);
      end
    end
    tick();
    #2;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.ext_pending_mask !== 32'd0) begin
      errors++;
      $display("FAIL drain_after: en=%b mask=%h, required 0/0", bus.rf_write_enable, bus.ext_pending_mask);
    end
    tick();
  endtask

  task automatic test_full();
    int acc = 0;
    int got = 0;
    do_reset();
    for (int c = 0; c < 40 && got < 5; c++) begin
      bus.wb_write_enable = (c < 6);
      bus.wb_write_reg    = 5'd1;
      bus.wb_write_value  = 32'(32'h100 + c);
      bus.ext_valid       = (acc < 5);
      bus.ext_rd          = 5'(10 + acc);
      bus.ext_value       = 32'(32'hF00 + acc);
      #2;
      if (c < 6) begin
        checks++;
        if (bus.ext_ready !== (acc < 4)) begin
          errors++;
          $display("FAIL full_ready c=%0d: ready=%b, required %b", c, bus.ext_ready, (acc < 4));
        end
      end
      if (bus.rf_write_enable === 1'b1 && bus.rf_write_reg !== 5'd1) begin
        checks++;
        if (bus.rf_write_reg !== 5'(10 + got) || bus.rf_write_value !== 32'(32'hF00 + got)) begin
          errors++;
          $display("FAIL full_order #%0d: reg=%0d val=%h, required %0d/%h",
                   got, bus.rf_write_reg, bus.rf_write_value, 10 + got, 32'hF00 + got);
        end
        got++;
      end
      if (bus.ext_valid && bus.ext_ready) acc++;
      tick();
    end
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL full_count: drained %0d, required 5", got);
    end
    drive_idle();
  endtask

  task automatic test_starvation();
    int nstall = 0;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c != 10) begin
        bus.wb_write_enable = 1'b1;
        bus.wb_write_reg    = 5'd2;
        bus.wb_write_value  = 32'(32'h200 + c);
      end
      bus.ext_valid = (c == 0);
      bus.ext_rd    = 5'd3;
      bus.ext_value = 32'h33;
      #2;
      checks++;
      if (bus.wb_stall !== (c == 9)) begin
        errors++;
        $display("FAIL starve_stall c=%0d: stall=%b, required %b", c, bus.wb_stall, (c == 9));
      end
      if (bus.wb_stall === 1'b1) nstall++;
      if (c == 9) begin
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd3 || bus.rf_write_value !== 32'h33) begin
          errors++;
          $display("FAIL starve_head: en=%b reg=%0d val=%h, required 1/3/33",
                   bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_value);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd2 || bus.rf_write_value !== 32'h209) begin
          errors++;
          $display("FAIL starve_held_wb: en=%b reg=%0d val=%h, required 1/2/209",
                   bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_value);
        end
      end
      tick();
    end
    checks++;
    if (nstall != 1) begin
      errors++;
      $display("FAIL starve_count: stalls=%0d, required 1", nstall);
    end
    drive_idle();
  endtask

  task automatic test_waw_kill();
    do_reset();
    bus.wb_write_enable = 1'b1;
    bus.wb_write_reg    = 5'd4;
    bus.wb_write_value  = 32'h44;
    bus.ext_valid       = 1'b1;
    bus.ext_rd          = 5'd9;
    bus.ext_value       = 32'hA;
    tick();
    bus.ext_valid      = 1'b0;
    bus.wb_write_reg   = 5'd9;
    bus.wb_write_value = 32'hB;
    #2;
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd9 ||
        bus.rf_write_value !== 32'hB || bus.ext_pending_mask !== 32'h200) begin
      errors++;
      $display("FAIL waw_wb: en=%b reg=%0d val=%h mask=%h, required 1/9/b/00000200",
               bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_value, bus.ext_pending_mask);
    end
    tick();
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (bus.rf_write_enable !== 1'b0 || bus.ext_pending_mask !== 32'd0) begin
        errors++;
        $display("FAIL waw_killed c=%0d: en=%b reg=%0d mask=%h, required en=0 mask=0",
                 c, bus.rf_write_enable, bus.rf_write_reg, bus.ext_pending_mask);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.wb_write_enable = 1'b1;
      bus.wb_write_reg    = 5'd1;
      bus.wb_write_value  = 32'(c);
      bus.ext_valid       = 1'b1;
      bus.ext_rd          = 5'(20 + c);
      bus.ext_value       = 32'(32'h500 + c);
      tick();
    end
    bus.ext_valid = 1'b0;
    #2;
    checks++;
    if (bus.ext_pending_mask !== 32'h0070_0000) begin
      errors++;
      $display("FAIL rstmid_mask: mask=%h, required 00700000", bus.ext_pending_mask);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.wb_stall !== 1'b0 ||
        bus.ext_ready !== 1'b0 || bus.ext_pending_mask !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: en=%b stall=%b ready=%b mask=%h, required all 0",
               bus.rf_write_enable, bus.wb_stall, bus.ext_ready, bus.ext_pending_mask);
    end
    mq.delete();
    starve = 0;
    tick();
    tick();
    rst = 1'b0;
    drive_idle();
    for (int c = 0; c < 6; c++) begin
      #2;
      checks++;
      if (bus.rf_write_enable !== 1'b0 || bus.ext_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after c=%0d: en=%b ready=%b, required 0/1",
                 c, bus.rf_write_enable, bus.ext_ready);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        bus.wb_write_enable = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        bus.wb_write_reg    = 5'($urandom_range(0, 7));
        bus.wb_write_value  = $urandom;
      end
      bus.ext_valid = ($urandom_range(0, 2) != 0);
      bus.ext_rd    = 5'($urandom_range(0, 7));
      bus.ext_value = $urandom;
      #2;
      model_expect();
      checks++;
      if (bus.rf_write_enable !== e_en) begin
        errors++;
        $display("FAIL rnd_en c=%0d: got %b, required %b", c, bus.rf_write_enable, e_en);
      end
      if (e_en) begin
        checks++;
        if (bus.rf_write_reg !== e_reg || bus.rf_write_value !== e_val) begin
          errors++;
          $display("FAIL rnd_data c=%0d: got %0d/%h, required %0d/%h",
                   c, bus.rf_write_reg, bus.rf_write_value, e_reg, e_val);
        end
      end
      checks++;
      if (bus.wb_stall !== e_stall) begin
        errors++;
        $display("FAIL rnd_stall c=%0d: got %b, required %b", c, bus.wb_stall, e_stall);
      end
      checks++;
      if (bus.ext_ready !== e_ready) begin
        errors++;
        $display("FAIL rnd_ready c=%0d: got %b, required %b", c, bus.ext_ready, e_ready);
      end
      checks++;
      if (bus.ext_pending_mask !== e_mask) begin
        errors++;
        $display("FAIL rnd_mask c=%0d: got %h, required %h", c, bus.ext_pending_mask, e_mask);
      end
      hold = e_stall;
      tick();
    end
    drive_idle();
  endtask

  initial begin
    starve = 0;
    test_reset();
    test_wb_only();
    test_drain();
    test_full();
    test_starvation();
    test_waw_kill();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the single register-file write port between the in-order WriteBack stage and a variable-latency external result source (load unit / multiply-divide unit). WriteBack has priority; external results are buffered in a small FIFO and drained on idle WriteBack cycles. A starvation counter forces a one-cycle pipeline stall so buffered results always retire. The block sits between WriteBack/external unit outputs and the RegFile write inputs.

## Interface
- DEPTH, 4, external-result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, cycles the FIFO head may wait before a forced stall; ≥1
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- wb_write_enable  input  1  WriteBack requests a write this cycle (no backpressure, except via wb_stall)
- wb_write_reg  input  5  WriteBack destination register
- wb_write_value  input  32  WriteBack data
- wb_stall  output  1  WriteBack write deferred this cycle; upstream must hold wb_* stable next cycle
- ext_valid  input  1  external result valid
- ext_ready  output  1  FIFO can accept; transfer when ext_valid && ext_ready
- ext_rd  input  5  external destination register
- ext_value  input  32  external data
- ext_pending_mask  output  32  bit R set when any queued entry targets R; bit 0 always 0
- rf_write_enable  output  1  RegFile write strobe
- rf_write_reg  output  5  RegFile write index
- rf_write_value  output  32  RegFile write data

## Operation
- State: FIFO (DEPTH entries of {rd, value}), read/write pointers with one extra wrap bit, count, starve_cnt (clog2(STARVE_LIMIT+1) bits).
- Grant per cycle, exactly one of:
  - FORCE: starve_cnt == STARVE_LIMIT and FIFO non-empty -> FIFO head written, dequeued; wb_stall = 1; WriteBack write not performed.
  - WB: wb_write_enable && wb_write_reg != 0 -> WriteBack written.
  - DRAIN: otherwise, FIFO non-empty -> head written, dequeued.
  - IDLE: rf_write_enable = 0.
- wb_write_enable with wb_write_reg == 0: treated as no request; never writes, never blocks DRAIN.
- starve_cnt: reset to 0 on any head dequeue or when FIFO empty; else +1 per cycle while head waits, saturating at STARVE_LIMIT.
- WAW kill: a WB-granted write to R invalidates every queued entry with rd == R (WriteBack is program-order younger by construction); invalidated entries are dequeued silently when they reach the head without using the port (that cycle may still be granted to WB).
- ext_ready = count < DEPTH (full rejects even if a dequeue happens same cycle).
- Accepted external result with ext_rd == 0: acknowledged, discarded, not enqueued.
- Simultaneous enqueue and dequeue: both happen; count unchanged. Pointers wrap modulo DEPTH.
- ext_pending_mask: OR of one-hot(rd) over valid, non-killed entries; updated the cycle after enqueue/dequeue/kill.

## Timing
- rf_write_*, wb_stall, ext_ready, ext_pending_mask are combinational from registered state and current inputs; RegFile samples at the same rising edge.
- WriteBack-to-RegFile latency: 0 cycles (same cycle) unless wb_stall, then exactly +1.
- wb_stall never asserts two consecutive cycles (starve_cnt clears on the forced dequeue).
- External minimum latency: accept cycle N -> earliest write cycle N+1.
- Reset (any time, including mid-drain): FIFO emptied, pointers/count/starve_cnt = 0; while rst high rf_write_enable = 0, wb_stall = 0, ext_ready = 0, ext_pending_mask = 0. After release ext_ready = 1.

## Configuration
- RF_ARB_BYPASS_EN defined: when FIFO empty, no WB grant, and ext_valid with ext_rd != 0, the external result is written the same cycle (not enqueued); ext_ready remains 1; external latency 0.
- Undefined: every external result passes through the FIFO; latency ≥1 cycle.

## Test plan
- WB only: wb_write_enable=1, reg 5, value 0xDEADBEEF -> same-cycle rf_write_enable=1, reg 5, value 0xDEADBEEF; ext_ready=1.
- Drain: enqueue ext rd 7 = 0x11 while WB idle -> write reg 7 = 0x11 next cycle (bypass off) or same cycle (RF_ARB_BYPASS_EN); mask bit 7 set only while queued.
- Full: WB writes every cycle, push 5 ext results with DEPTH=4 -> ext_ready=0 after 4th accept; 5th held until a slot frees; no loss, FIFO order kept.
- Starvation: queue 1 entry, WB writes every cycle, STARVE_LIMIT=8 -> exactly 8 cycles after enqueue wb_stall=1 for one cycle, head written, held WB write lands next cycle.
- WAW kill: queue rd 9 = 0xA, then WB writes reg 9 = 0xB -> final reg 9 = 0xB; entry never written; mask bit 9 clears next cycle.
- Reset mid-operation: 3 entries queued, assert rst -> outputs 0 immediately, no queued write after release, ext_ready=1.
